// File: rtl/dec_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dec_rr_arbiter
// Brief    : 8-way round-robin arbiter with hold timeout; index/enable plus one-hot grant.
// Revision : 1.0
// ============================================================================
module dec_rr_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] gnt_idx,
   output logic       gnt_en,
   output logic [7:0] gnt_oh,
   output logic       timeout
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] c_hold_last = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

   state_t           r_state;
   logic [2:0]       r_ptr;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [2:0]       r_gnt_idx;
   logic             r_gnt_en;
   logic             r_timeout;

   logic [2:0]       w_pick;
   logic             w_found;
   logic [2:0]       w_scan;
   logic             w_rel_done;
   logic             w_rel_drop;
   logic             w_rel_expire;

   // Scan from the highest offset down so the nearest requester to r_ptr wins.
   always_comb begin
      w_pick  = r_ptr;
      w_found = 1'b0;
      w_scan  = r_ptr;
      for (int k = 7; k >= 0; k--) begin
         w_scan = r_ptr + 3'(k);
         if (req[w_scan]) begin
            w_pick  = w_scan;
            w_found = 1'b1;
         end
      end
   end

   assign w_rel_done   = done;
   assign w_rel_drop   = ~req[r_gnt_idx];
   assign w_rel_expire = (r_hold_cnt == c_hold_last);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_ptr      <= 3'd0;
         r_hold_cnt <= '0;
         r_gnt_idx  <= 3'd0;
         r_gnt_en   <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt_idx  <= w_pick;
                  r_gnt_en   <= 1'b1;
                  r_hold_cnt <= '0;
                  r_state    <= GRANT;
               end else begin
                  r_gnt_en <= 1'b0;
               end
            end
            GRANT: begin
               if (w_rel_done || w_rel_drop || w_rel_expire) begin
                  r_gnt_en  <= 1'b0;
                  r_ptr     <= r_gnt_idx + 3'd1;
                  r_timeout <= w_rel_expire && !w_rel_done && !w_rel_drop;
                  r_state   <= IDLE;
               end else if (r_hold_cnt != c_cnt_max) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= IDLE;
               r_gnt_en <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_idx = r_gnt_idx;
   assign gnt_en  = r_gnt_en;
   assign timeout = r_timeout;
   assign gnt_oh  = r_gnt_en ? (8'b1 << r_gnt_idx) : 8'b0;

endmodule
`default_nettype wire
